bsearch_req_arbiter: RTL and testbench
======================================

// Module: bsearch_req_arbiter
// PURPOSE
//  Shares one binary_search engine between NUM_REQ requesters with round-robin arbitration.
//  Accepts one key at a time, drives the engine request interface and waits for a hit,
//  no-match or timeout, then returns the result to the granted requester only.
//  Sits between the requesters and the engine; the cpu table-load path is not touched.
// PARAMETERS
//  NUM_REQ        4                   number of requesters (>=2)
//  DATA_WIDTH     32                  key width; must match the engine
//  DEPTH          1024                engine table depth; IDX_W = $clog2(DEPTH)
//  TIMEOUT_CYC    $clog2(DEPTH)+4     WAIT cycles before a search is declared timed out
// PORTS
//  Clk            in   1                    clock
//  Rst_n          in   1                    reset, asynchronous assert, active-low
//  table_ready    in   1                    engine table loaded; gates new grants
//  req_valid      in   NUM_REQ              per-requester request
//  req_key        in   NUM_REQ*DATA_WIDTH   keys; requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready      out  NUM_REQ              one-hot, 1-cycle accept pulse
//  rsp_valid      out  NUM_REQ              one-hot, 1-cycle result pulse
//  rsp_index      out  IDX_W                matched index; 0 on no-match or timeout
//  rsp_no_match   out  1                    qualified by |rsp_valid: key absent
//  rsp_timeout    out  1                    qualified by |rsp_valid: engine did not answer
//  eng_key        out  DATA_WIDTH           engine request_key
//  eng_key_valid  out  1                    engine request_key_valid, 1-cycle pulse
//  eng_index      in   IDX_W                engine response_index
//  eng_rsp_valid  in   1                    engine response_valid
//  eng_no_match   in   1                    engine no_match_found
//  busy           out  1                    state != IDLE
//  stray_rsp      out  1                    1-cycle pulse: engine response outside WAIT, dropped
// BEHAVIOUR
//  Reset (Rst_n=0, async):
//   - All outputs go to 0. State goes to IDLE, wait counter to 0, last_grant to NUM_REQ-1 (first grant goes to req 0).
//   - Reset mid-search abandons the search; no rsp_valid is issued for it.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE. One search is in flight at a time.
//  IDLE:
//   - If table_ready and |req_valid, grant g = first set req_valid scanning from last_grant+1 with wrap.
//   - Latch req_key[g] and the one-hot grant; pulse req_ready[g] this cycle; go to ISSUE.
//   - Otherwise stay in IDLE with no pulses.
//  ISSUE:
//   - eng_key_valid=1 for exactly this cycle; eng_key = latched key.
//   - eng_key holds the latched key until the next grant.
//   - Clear the wait counter; go to WAIT.
//  WAIT:
//   - Counter increments each cycle.
//   - eng_no_match=1: no_match=1, index=0. No-match wins if eng_rsp_valid is asserted in the same cycle.
//   - Else eng_rsp_valid=1: latch eng_index, no_match=0.
//   - Else counter==TIMEOUT_CYC-1: timeout=1, index=0.
//   - Any of the three outcomes moves to RESP.
//  RESP:
//   - rsp_valid[g]=1 for one cycle with rsp_index, rsp_no_match and rsp_timeout; last_grant<=g; go to IDLE.
//   - rsp_* data holds until the next RESP.
//  Latency:
//   - req_ready in cycle T, eng_key_valid in T+1.
//   - Engine response seen in cycle W: rsp_valid in W+1. Earliest rsp_valid is T+3.
//   - Next grant is possible in the cycle after RESP.
//  Requester rules:
//   - Hold req_valid and req_key stable until req_ready.
//   - Dropping req_valid before req_ready withdraws the request.
//   - req_valid seen in the cycle of its own req_ready is treated as consumed.
//  Boundaries:
//   - table_ready falling mid-search: the search completes normally; no new grant until it rises.
//   - Engine response in IDLE/ISSUE/RESP: dropped and stray_rsp pulses. The FSM and all rsp_* outputs are unaffected.
//   - All requesters asserted continuously: grants rotate 0,1,..,NUM_REQ-1,0; no requester waits more than NUM_REQ-1 searches.
//   - Only one requester asserted: it is re-granted every search.
// TESTING
//  1. Load table with mem[i]=2*i, table_ready=1; req0 key=0x64 -> req_ready[0], eng_key_valid next cycle, rsp_valid[0] with rsp_index=0x32, no_match=0.
//  2. req0..3 held valid with keys 2,4,6,8 -> grant order 0,1,2,3; rsp_index 1,2,3,4 on rsp_valid[0..3] respectively.
//  3. req2 key=0x7 (odd, absent) -> rsp_valid[2], rsp_no_match=1, rsp_index=0.
//  4. Engine model never responds -> rsp_timeout=1 exactly TIMEOUT_CYC (14) WAIT cycles after eng_key_valid. A late eng_rsp_valid in IDLE pulses stray_rsp.
//  5. table_ready=0 with req1 valid -> no req_ready for 20 cycles. Raise table_ready -> req_ready[1] the same cycle.
//  6. Assert Rst_n=0 during WAIT -> all outputs 0 immediately, no rsp_valid. After release, req3 alone -> search completes with a correct index.

Source files
------------

// File: rtl/bsearch_req_arbiter_if.sv
// Requester and engine-request bundle for bsearch_req_arbiter.
// slave  : arbiter view (takes requests, drives the engine request side)
// master : requesters plus engine response side
interface bsearch_req_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 10
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_key;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [IDX_W-1:0]              rsp_index;
  logic                          rsp_no_match;
  logic                          rsp_timeout;
  logic [DATA_WIDTH-1:0]         eng_key;
  logic                          eng_key_valid;
  logic [IDX_W-1:0]              eng_index;
  logic                          eng_rsp_valid;
  logic                          eng_no_match;

  modport slave (
    input  req_valid, req_key, eng_index, eng_rsp_valid, eng_no_match,
    output req_ready, rsp_valid, rsp_index, rsp_no_match, rsp_timeout,
           eng_key, eng_key_valid
  );

  modport master (
    output req_valid, req_key, eng_index, eng_rsp_valid, eng_no_match,
    input  req_ready, rsp_valid, rsp_index, rsp_no_match, rsp_timeout,
           eng_key, eng_key_valid
  );
endinterface

// File: rtl/bsearch_req_arbiter.sv
// Round-robin front end sharing one binary_search engine between NUM_REQ
// requesters. One search in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
module bsearch_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int TIMEOUT_CYC = $clog2(DEPTH) + 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   table_ready,
  bsearch_req_arbiter_if.slave   bus,
  output logic                   busy,
  output logic                   stray_rsp
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam int          GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          CW    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned NR    = NUM_REQ;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                                 state, state_nxt;
  logic   [GW-1:0]                        last_grant;
  logic   [GW-1:0]                        grant_idx;
  logic   [NUM_REQ-1:0]                   grant_oh;
  logic   [GW-1:0]                        sel_idx;
  logic   [GW-1:0]                        cand;
  logic                                   sel_found;
  logic   [NUM_REQ-1:0]                   sel_oh;
  logic                                   grant_now;
  logic   [NUM_REQ-1:0][DATA_WIDTH-1:0]   key_arr;
  logic   [DATA_WIDTH-1:0]                key_q;
  logic   [CW-1:0]                        wait_cnt;
  logic                                   eng_resp;
  logic                                   timed_out;
  logic                                   wait_done;
  logic   [IDX_W-1:0]                     res_index;
  logic                                   res_no_match;
  logic                                   res_timeout;

  assign key_arr   = bus.req_key;
  assign eng_resp  = bus.eng_rsp_valid | bus.eng_no_match;
  assign timed_out = (wait_cnt == CW'(TIMEOUT_CYC - 1));
  assign wait_done = eng_resp | timed_out;
  assign grant_now = (state == IDLE) && table_ready && sel_found;

  // Round-robin pick: first valid requester after last_grant, with wrap
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      cand = GW'((32'(last_grant) + k) % NR);
      if (!sel_found && bus.req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_oh = sel_found ? (NUM_REQ'(1) << sel_idx) : '0;
  end

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant_now) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, key, wait counter and result capture
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_grant   <= GW'(NUM_REQ - 1);
      grant_idx    <= '0;
      grant_oh     <= '0;
      key_q        <= '0;
      wait_cnt     <= '0;
      res_index    <= '0;
      res_no_match <= 1'b0;
      res_timeout  <= 1'b0;
    end else begin
      if (grant_now) begin
        grant_idx <= sel_idx;
        grant_oh  <= sel_oh;
        key_q     <= key_arr[sel_idx];
      end
      case (state)
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // Result registers only move on WAIT exit, so rsp_* hold between RESPs
          if (bus.eng_no_match) begin
            res_index    <= '0;
            res_no_match <= 1'b1;
            res_timeout  <= 1'b0;
          end else if (bus.eng_rsp_valid) begin
            res_index    <= bus.eng_index;
            res_no_match <= 1'b0;
            res_timeout  <= 1'b0;
          end else if (timed_out) begin
            res_index    <= '0;
            res_no_match <= 1'b0;
            res_timeout  <= 1'b1;
          end
        end
        RESP:    last_grant <= grant_idx;
        default: ;
      endcase
    end
  end

  // Outputs; combinational pulses are held low while reset is asserted
  always_comb begin
    bus.req_ready     = (grant_now && Rst_n) ? sel_oh : '0;
    bus.eng_key_valid = (state == ISSUE);
    bus.eng_key       = key_q;
    bus.rsp_valid     = (state == RESP) ? grant_oh : '0;
    bus.rsp_index     = res_index;
    bus.rsp_no_match  = res_no_match;
    bus.rsp_timeout   = res_timeout;
    busy              = (state != IDLE);
    stray_rsp         = Rst_n && eng_resp && (state != WAIT);
  end

endmodule

// File: tb/tb_bsearch_req_arbiter.sv
// Self-checking bench for bsearch_req_arbiter: engine model backed by a
// mem[i]=2*i table, a grant model, and a scoreboard of expected results.
module tb_bsearch_req_arbiter;
  localparam int NR    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int IW    = 10;
  localparam int TO    = 14;

  logic clk, rst_n, table_ready, busy, stray_rsp;

  bsearch_req_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IDX_W(IW)) bus();

  bsearch_req_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .Clk(clk), .Rst_n(rst_n), .table_ready(table_ready), .bus(bus),
    .busy(busy), .stray_rsp(stray_rsp)
  );

  typedef struct {
    int           id;
    logic [IW-1:0] idx;
    logic         nm;
    logic         to;
    logic [DW-1:0] key;
  } exp_t;

  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0;
  int ready_cnt = 0, rsp_cnt = 0, stray_cnt = 0;
  int last_ready_cyc = 0, last_ekv_cyc = 0, last_rsp_cyc = 0, eng_rsp_cyc = 0;
  int grant_log[$];
  int model_last = NR - 1;
  int hold_left = 0;
  int eng_mode = 0;
  int eng_lat = 1;
  logic [DW-1:0] keys [NR];
  int            last_id = -1;
  logic [IW-1:0] last_idx;
  logic          last_nm, last_to;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic request(input int i, input logic [DW-1:0] k);
    keys[i] = k;
    bus.req_key[i*DW +: DW] = k;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !busy && bus.req_valid == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Engine model: table mem[i] = 2*i; absent keys raise no_match together with
  // a bogus rsp_valid/index so no_match priority is exercised
  initial begin
    logic [DW-1:0] k, half;
    bus.eng_rsp_valid = 1'b0;
    bus.eng_no_match  = 1'b0;
    bus.eng_index     = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.eng_key_valid === 1'b1 && eng_mode == 0) begin
        k = bus.eng_key;
        half = k >> 1;
        repeat (eng_lat) @(posedge clk);
        #1;
        if (k[0] == 1'b0 && half < DEPTH) begin
          bus.eng_index = half[IW-1:0];
          bus.eng_no_match = 1'b0;
        end else begin
          bus.eng_index = IW'(5);
          bus.eng_no_match = 1'b1;
        end
        bus.eng_rsp_valid = 1'b1;
        eng_rsp_cyc = cyc;
        @(posedge clk); #1;
        bus.eng_rsp_valid = 1'b0;
        bus.eng_no_match  = 1'b0;
        bus.eng_index     = '0;
      end
    end
  end

  // Monitor: grant model, scoreboard push on req_ready, pop/compare on rsp_valid
  initial begin
    logic [NR-1:0] drop, exp_oh;
    int g, c;
    exp_t e;
    logic [DW-1:0] hk;
    forever begin
      @(negedge clk);
      drop = '0;
      if (rst_n === 1'b1) begin
        if (|bus.req_ready) begin
          g = -1;
          for (int k = 1; k <= NR; k++) begin
            c = (model_last + k) % NR;
            if (g < 0 && bus.req_valid[c]) g = c;
          end
          exp_oh = (g < 0) ? '0 : (NR'(1) << g);
          checks++;
          if (bus.req_ready !== exp_oh || table_ready !== 1'b1) begin
            errors++;
            $display("FAIL grant: req_ready=%b expected %b (table_ready=%b) cyc=%0d", bus.req_ready, exp_oh, table_ready, cyc);
          end
          if (g < 0) g = 0;
          model_last = g;
          e.id = g;
          e.key = keys[g];
          hk = keys[g] >> 1;
          if (eng_mode != 0) begin
            e.idx = '0; e.nm = 1'b0; e.to = 1'b1;
          end else if (keys[g][0] == 1'b0 && hk < DEPTH) begin
            e.idx = hk[IW-1:0]; e.nm = 1'b0; e.to = 1'b0;
          end else begin
            e.idx = '0; e.nm = 1'b1; e.to = 1'b0;
          end
          sb.push_back(e);
          grant_log.push_back(g);
          ready_cnt++;
          last_ready_cyc = cyc;
          if (hold_left > 0) hold_left--;
          else drop[g] = 1'b1;
        end
        if (bus.eng_key_valid === 1'b1) begin
          last_ekv_cyc = cyc;
          checks++;
          if (sb.size() == 0 || bus.eng_key !== sb[0].key) begin
            errors++;
            $display("FAIL eng_key: got %h expected %h", bus.eng_key, (sb.size() == 0) ? 32'hx : sb[0].key);
          end
          checks++;
          if (cyc != last_ready_cyc + 1) begin
            errors++;
            $display("FAIL ekv_latency: eng_key_valid at cycle %0d, required %0d", cyc, last_ready_cyc + 1);
          end
        end
        if (|bus.rsp_valid) begin
          last_rsp_cyc = cyc;
          rsp_cnt++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: rsp_valid=%b with nothing outstanding", bus.rsp_valid);
          end else begin
            e = sb.pop_front();
            exp_oh = NR'(1) << e.id;
            if ({bus.rsp_valid, bus.rsp_index, bus.rsp_no_match, bus.rsp_timeout} !== {exp_oh, e.idx, e.nm, e.to}) begin
              errors++;
              $display("FAIL rsp: valid=%b idx=%h nm=%b to=%b expected valid=%b idx=%h nm=%b to=%b",
                       bus.rsp_valid, bus.rsp_index, bus.rsp_no_match, bus.rsp_timeout, exp_oh, e.idx, e.nm, e.to);
            end
          end
          last_id = $clog2(bus.rsp_valid);
          last_idx = bus.rsp_index;
          last_nm = bus.rsp_no_match;
          last_to = bus.rsp_timeout;
        end
        if (stray_rsp === 1'b1) stray_cnt++;
      end
      @(posedge clk); #1;
      bus.req_valid = bus.req_valid & ~drop;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    table_ready = 1'b1;
    bus.req_key = '0;
    bus.req_valid = '1;
    repeat (2) @(posedge clk);
    #1 bus.eng_rsp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.eng_key_valid, busy, stray_rsp} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b ekv=%b busy=%b stray=%b, all required 0",
               bus.req_ready, bus.rsp_valid, bus.eng_key_valid, busy, stray_rsp);
    end
    checks++;
    if ({bus.eng_key, bus.rsp_index, bus.rsp_no_match, bus.rsp_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_data: eng_key=%h rsp_index=%h nm=%b to=%b, all required 0",
               bus.eng_key, bus.rsp_index, bus.rsp_no_match, bus.rsp_timeout);
    end
    @(posedge clk); #1;
    bus.eng_rsp_valid = 1'b0;
    bus.req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL reset_release: busy=%b req_ready=%b required 0/0", busy, bus.req_ready);
    end
  endtask

  task automatic test_rotation();
    bit ok;
    eng_lat = 2;
    hold_left = 4;
    grant_log.delete();
    @(posedge clk); #1;
    request(0, 32'd2); request(1, 32'd4); request(2, 32'd6); request(3, 32'd8);
    wait_done(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rotation_done: searches did not complete, got 0 required 1"); end
    checks++;
    if (grant_log.size() != 8) begin
      errors++;
      $display("FAIL rotation_count: got %0d grants, required 8", grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (grant_log[i] != i % NR) begin
          errors++;
          $display("FAIL rotation_order[%0d]: got req %0d, required %0d", i, grant_log[i], i % NR);
        end
      end
    end
  endtask

  task automatic test_basic();
    bit ok;
    int c0;
    int lats [2] = '{1, 4};
    for (int j = 0; j < 2; j++) begin
      eng_lat = lats[j];
      c0 = rsp_cnt;
      @(posedge clk); #1;
      request(0, 32'h64);
      wait_done(100, ok);
      checks++;
      if (!ok || rsp_cnt != c0 + 1) begin
        errors++;
        $display("FAIL basic_count: got %0d responses (done=%0d), required 1", rsp_cnt - c0, ok);
      end
      checks++;
      if (last_rsp_cyc - last_ready_cyc != 2 + eng_lat || last_rsp_cyc != eng_rsp_cyc + 1) begin
        errors++;
        $display("FAIL basic_latency: ready->rsp %0d cycles, required %0d; eng->rsp %0d required 1",
                 last_rsp_cyc - last_ready_cyc, 2 + eng_lat, last_rsp_cyc - eng_rsp_cyc);
      end
      checks++;
      if (last_id != 0 || last_idx !== 10'h32 || last_nm !== 1'b0) begin
        errors++;
        $display("FAIL basic_result: id=%0d idx=%h nm=%b, required 0/032/0", last_id, last_idx, last_nm);
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_index, bus.rsp_no_match, bus.rsp_timeout} !== {4'b0, 10'h32, 2'b00}) begin
        errors++;
        $display("FAIL basic_hold: valid=%b idx=%h nm=%b to=%b, required 0/032/0/0",
                 bus.rsp_valid, bus.rsp_index, bus.rsp_no_match, bus.rsp_timeout);
      end
    end
  endtask

  task automatic test_no_match();
    bit ok;
    logic [DW-1:0] ks [2] = '{32'h7, 32'h800};
    eng_lat = 3;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      request(2, ks[j]);
      wait_done(100, ok);
      checks++;
      if (!ok || last_id != 2 || last_nm !== 1'b1 || last_idx !== '0 || last_to !== 1'b0) begin
        errors++;
        $display("FAIL no_match: key=%h done=%0d id=%0d nm=%b idx=%h to=%b, required 2/1/000/0",
                 ks[j], ok, last_id, last_nm, last_idx, last_to);
      end
      checks++;
      if (bus.rsp_no_match !== 1'b1 || bus.rsp_valid !== '0) begin
        errors++;
        $display("FAIL no_match_hold: nm=%b valid=%b, required 1/0", bus.rsp_no_match, bus.rsp_valid);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int s0;
    eng_mode = 1;
    @(posedge clk); #1;
    request(1, 32'h10);
    wait_done(100, ok);
    checks++;
    if (!ok || last_rsp_cyc - last_ekv_cyc != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: ekv->rsp %0d cycles (done=%0d), required %0d", last_rsp_cyc - last_ekv_cyc, ok, TO + 1);
    end
    checks++;
    if (last_id != 1 || last_to !== 1'b1 || last_idx !== '0 || last_nm !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result: id=%0d to=%b idx=%h nm=%b, required 1/1/000/0", last_id, last_to, last_idx, last_nm);
    end
    eng_mode = 0;
    // late engine answer while idle
    s0 = stray_cnt;
    @(posedge clk); #1;
    bus.eng_index = 10'h3;
    bus.eng_rsp_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({stray_rsp, busy, bus.rsp_valid, bus.rsp_index, bus.rsp_timeout} !== {1'b1, 1'b0, 4'b0, 10'h0, 1'b1}) begin
      errors++;
      $display("FAIL stray_idle: stray=%b busy=%b valid=%b idx=%h to=%b, required 1/0/0/000/1",
               stray_rsp, busy, bus.rsp_valid, bus.rsp_index, bus.rsp_timeout);
    end
    @(posedge clk); #1;
    bus.eng_rsp_valid = 1'b0;
    bus.eng_index = '0;
    @(negedge clk); #1;
    checks++;
    if (stray_rsp !== 1'b0 || stray_cnt != s0 + 1) begin
      errors++;
      $display("FAIL stray_pulse: stray=%b count=%0d, required 0 and %0d", stray_rsp, stray_cnt - s0, 1);
    end
    // engine no_match during ISSUE is dropped; the search still completes
    eng_lat = 2;
    @(posedge clk); #1;
    request(0, 32'h64);
    @(posedge clk); #1;
    bus.eng_no_match = 1'b1;
    @(negedge clk);
    checks++;
    if (stray_rsp !== 1'b1 || bus.eng_key_valid !== 1'b1) begin
      errors++;
      $display("FAIL stray_issue: stray=%b ekv=%b, required 1/1", stray_rsp, bus.eng_key_valid);
    end
    @(posedge clk); #1;
    bus.eng_no_match = 1'b0;
    wait_done(100, ok);
    checks++;
    if (!ok || last_id != 0 || last_idx !== 10'h32 || last_nm !== 1'b0) begin
      errors++;
      $display("FAIL stray_issue_result: done=%0d id=%0d idx=%h nm=%b, required 1/0/032/0", ok, last_id, last_idx, last_nm);
    end
  endtask

  task automatic test_table_ready();
    bit ok, bad;
    int r0, c0;
    eng_lat = 1;
    table_ready = 1'b0;
    @(posedge clk); #1;
    request(1, 32'h20);
    r0 = ready_cnt;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.req_ready !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL table_gate: req_ready seen while table_ready=0, required none"); end
    @(posedge clk); #1;
    table_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL table_rise: req_ready=%b, required 0010", bus.req_ready);
    end
    c0 = rsp_cnt;
    @(posedge clk); #1;
    table_ready = 1'b0;
    request(3, 32'h44);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (rsp_cnt == c0 + 1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || last_id != 1 || last_idx !== 10'h10) begin
      errors++;
      $display("FAIL table_fall_complete: done=%0d id=%0d idx=%h, required 1/1/010", ok, last_id, last_idx);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (ready_cnt != r0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL table_fall_hold: grants=%0d busy=%b, required 1/0", ready_cnt - r0, busy);
    end
    @(posedge clk); #1;
    table_ready = 1'b1;
    wait_done(100, ok);
    checks++;
    if (!ok || ready_cnt != r0 + 2 || last_id != 3 || last_idx !== 10'h22) begin
      errors++;
      $display("FAIL table_resume: done=%0d grants=%0d id=%0d idx=%h, required 1/2/3/022", ok, ready_cnt - r0, last_id, last_idx);
    end
  endtask

  task automatic test_single_requester();
    bit ok;
    int bad;
    hold_left = 2;
    grant_log.delete();
    @(posedge clk); #1;
    request(1, 32'h3FE);
    wait_done(200, ok);
    bad = 0;
    foreach (grant_log[i]) if (grant_log[i] != 1) bad++;
    checks++;
    if (!ok || grant_log.size() != 3 || bad != 0) begin
      errors++;
      $display("FAIL single_regrant: done=%0d grants=%0d others=%0d, required 1/3/0", ok, grant_log.size(), bad);
    end
    checks++;
    if (last_idx !== 10'h1FF) begin
      errors++;
      $display("FAIL single_result: idx=%h, required 1ff", last_idx);
    end
  endtask

  task automatic test_reset_mid_search();
    bit ok, seen;
    int r0;
    eng_mode = 1;
    @(posedge clk); #1;
    request(0, 32'h40);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.eng_key_valid === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_issue: eng_key_valid never seen, required 1"); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.eng_key_valid, busy, stray_rsp, bus.eng_key, bus.rsp_index,
         bus.rsp_no_match, bus.rsp_timeout} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: ready=%b valid=%b ekv=%b busy=%b stray=%b key=%h idx=%h nm=%b to=%b, all required 0",
               bus.req_ready, bus.rsp_valid, bus.eng_key_valid, busy, stray_rsp, bus.eng_key, bus.rsp_index,
               bus.rsp_no_match, bus.rsp_timeout);
    end
    sb.delete();
    model_last = NR - 1;
    r0 = rsp_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    eng_mode = 0;
    repeat (20) @(negedge clk);
    checks++;
    if (rsp_cnt != r0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_abandon: responses=%0d busy=%b, required 0/0", rsp_cnt - r0, busy);
    end
    @(posedge clk); #1;
    request(3, 32'h1F4);
    wait_done(100, ok);
    checks++;
    if (!ok || last_id != 3 || last_idx !== 10'hFA || last_nm !== 1'b0) begin
      errors++;
      $display("FAIL mid_recover: done=%0d id=%0d idx=%h nm=%b, required 1/3/0fa/0", ok, last_id, last_idx, last_nm);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_basic();
    test_no_match();
    test_timeout();
    test_table_ready();
    test_single_requester();
    test_reset_mid_search();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
